// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, credit width and limits for the vending controller
package vend_pkg;
    localparam int CW = 4;
    localparam int CMAX = 15;
    typedef enum logic [2:0] {IDLE, CREDIT, VEND, CHANGE, FAULT} state_t;
    typedef logic [CW:0] sum_t;
    function automatic sum_t coin_val(input logic c1, input logic c2);
        return sum_t'({c2, c1});
    endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: coin, purchase and dispenser signals between the controller and its environment
interface vend_if;
    import vend_pkg::*;
    logic coin1;
    logic coin2;
    logic [1:0] sel;
    logic vend_req;
    logic cancel;
    logic disp_ack;
    logic disp_done;
    logic disp_start;
    logic [1:0] disp_id;
    logic chg_pulse;
    logic coin_rej;
    logic insuff;
    logic [CW-1:0] credit;
    logic busy;
    logic fault;
    modport master (
        output coin1, coin2, sel, vend_req, cancel, disp_ack, disp_done,
        input disp_start, disp_id, chg_pulse, coin_rej, insuff, credit, busy, fault
    );
    modport slave (
        input coin1, coin2, sel, vend_req, cancel, disp_ack, disp_done,
        output disp_start, disp_id, chg_pulse, coin_rej, insuff, credit, busy, fault
    );
endinterface

// File: rtl/vend_timer.sv
// vend_timer: shared cycle counter, dispense timeout in VEND and pulse/gap pacing in CHANGE
module vend_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tmo,
    output logic phase
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    // count while the controller is busy, restart whenever it changes activity
    always_ff @(posedge clk)
        cnt <= (!rst || !run || clr) ? '0 : cnt + W'(1);
    assign tmo = cnt == W'(TIMEOUT - 1);
    assign phase = cnt[0];
endmodule

// File: rtl/vend_seq_ctrl.sv
// vend_seq_ctrl: coin credit, product vend, dispenser handshake with timeout, and change return
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE0 = 3,
    parameter int PRICE1 = 4,
    parameter int PRICE2 = 5,
    parameter int PRICE3 = 8,
    parameter int TIMEOUT = 1000
) (
    input logic clk,
    input logic rst,
    vend_if.slave bus
);
    localparam logic [CW-1:0] PRICE [4] = '{CW'(PRICE0), CW'(PRICE1), CW'(PRICE2), CW'(PRICE3)};
    state_t state;
    logic tmo, phase, coin_ev, vend_end;
    logic [CW-1:0] price;
    sum_t sum, refund;
    assign coin_ev = bus.coin1 | bus.coin2;
    assign sum = {1'b0, bus.credit} + coin_val(bus.coin1, bus.coin2);
    assign price = PRICE[bus.sel];
    assign refund = {1'b0, bus.credit} + {1'b0, PRICE[bus.disp_id]};
    assign vend_end = state == VEND && (bus.disp_done || tmo);
    vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .run(state == VEND || state == CHANGE),
        .clr(vend_end),
        .tmo(tmo),
        .phase(phase)
    );
    // main controller: arbitration cancel > vend > coin, dispense handshake, change payout
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            bus.credit <= '0;
            bus.disp_start <= 1'b0;
            bus.disp_id <= 2'd0;
            bus.chg_pulse <= 1'b0;
            bus.coin_rej <= 1'b0;
            bus.insuff <= 1'b0;
            bus.busy <= 1'b0;
            bus.fault <= 1'b0;
        end else begin
            bus.coin_rej <= 1'b0;
            bus.insuff <= 1'b0;
            bus.chg_pulse <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (bus.cancel && state == CREDIT) begin
                        state <= CHANGE;
                        bus.busy <= 1'b1;
                        bus.coin_rej <= coin_ev;
                    end else if (bus.vend_req) begin
                        bus.coin_rej <= coin_ev;
                        if (bus.credit >= price) begin
                            bus.credit <= bus.credit - price;
                            state <= VEND;
                            bus.busy <= 1'b1;
                            bus.disp_start <= 1'b1;
                            bus.disp_id <= bus.sel;
                        end else
                            bus.insuff <= 1'b1;
                    end else if (coin_ev) begin
                        if (sum > sum_t'(CMAX))
                            bus.coin_rej <= 1'b1;
                        else begin
                            bus.credit <= sum[CW-1:0];
                            state <= CREDIT;
                        end
                    end
                end
                VEND: begin
                    bus.coin_rej <= coin_ev;
                    if (bus.disp_ack)
                        bus.disp_start <= 1'b0;
                    if (bus.disp_done) begin
                        bus.disp_start <= 1'b0;
                        state <= bus.credit != '0 ? CHANGE : IDLE;
                        bus.busy <= bus.credit != '0;
                    end else if (tmo) begin
                        bus.disp_start <= 1'b0;
                        bus.fault <= 1'b1;
                        bus.credit <= refund[CW-1:0];
                        state <= FAULT;
                        bus.busy <= 1'b0;
                    end
                end
                FAULT: begin
                    bus.coin_rej <= coin_ev;
                    state <= CHANGE;
                    bus.busy <= 1'b1;
                end
                CHANGE: begin
                    bus.coin_rej <= coin_ev;
                    if (!phase) begin
                        if (bus.credit == '0) begin
                            state <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.chg_pulse <= 1'b1;
                            bus.credit <= bus.credit - CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vend_seq_ctrl.sv
// tb_vend_seq_ctrl: directed scenarios plus randomized transactions against a credit-level model
module tb_vend_seq_ctrl;
    localparam int TO = 20;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int fails = 0;
    int m_credit = 0;
    int price_of [4] = '{3, 4, 5, 8};
    vend_if bus();
    vend_seq_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.coin1 = 0; bus.coin2 = 0; bus.sel = 0; bus.vend_req = 0;
        bus.cancel = 0; bus.disp_ack = 0; bus.disp_done = 0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_credit"}, bus.credit, 0);
        chk({tag, "_disp_start"}, bus.disp_start, 0);
        chk({tag, "_outs"}, {bus.chg_pulse, bus.coin_rej, bus.insuff, bus.busy, bus.fault}, 0);
    endtask

    task automatic coin(input int v);
        int exp_rej;
        bus.coin1 = v[0]; bus.coin2 = v[1];
        tick();
        clear_in();
        exp_rej = (m_credit + v > 15) ? 1 : 0;
        if (!exp_rej) m_credit += v;
        chk("coin_rej", bus.coin_rej, exp_rej);
        chk("coin_credit", bus.credit, m_credit);
    endtask

    // called on the cycle CHANGE is entered; expects n pulses two cycles apart, then IDLE
    task automatic change_out(input int n);
        int cyc = 0, pulses = 0, last = -1, bad = 0;
        while (bus.busy && cyc < 40) begin
            tick();
            cyc++;
            if (bus.chg_pulse) begin
                pulses++;
                if (cyc - last != 2) bad++;
                last = cyc;
            end
        end
        chk("chg_count", pulses, n);
        chk("chg_spacing", bad, 0);
        chk("chg_exit_cycle", cyc, 2 * n + 1);
        chk("chg_end_credit", bus.credit, 0);
        m_credit = 0;
    endtask

    task automatic cancel_op();
        bus.cancel = 1;
        tick();
        clear_in();
        chk("cancel_busy", bus.busy, m_credit > 0);
        if (m_credit > 0) change_out(m_credit);
    endtask

    task automatic vend(input int s, input int a, input int d, input bit use_ack, input bit poke);
        bus.vend_req = 1; bus.sel = s[1:0];
        tick();
        clear_in();
        if (m_credit < price_of[s]) begin
            chk("insuff", bus.insuff, 1);
            chk("insuff_credit", bus.credit, m_credit);
            chk("insuff_busy", {bus.busy, bus.disp_start}, 0);
            return;
        end
        m_credit -= price_of[s];
        chk("vend_start", bus.disp_start, 1);
        chk("vend_id", bus.disp_id, s);
        chk("vend_credit", bus.credit, m_credit);
        chk("vend_busy", bus.busy, 1);
        if (poke) begin
            bus.coin1 = 1;
            tick();
            clear_in();
            chk("vend_coin_rej", bus.coin_rej, 1);
            chk("vend_coin_credit", bus.credit, m_credit);
        end
        for (int i = 0; i < a; i++) tick();
        chk("vend_start_hold", bus.disp_start, 1);
        if (use_ack) begin
            bus.disp_ack = 1;
            tick();
            clear_in();
            chk("ack_drop", bus.disp_start, 0);
            for (int i = 0; i < d; i++) tick();
        end
        bus.disp_done = 1;
        tick();
        clear_in();
        chk("done_start", bus.disp_start, 0);
        chk("done_busy", bus.busy, m_credit > 0);
        if (m_credit > 0) change_out(m_credit);
        chk("vend_idle", bus.busy, 0);
    endtask

    initial begin
        int k, cnt, op;
        clear_in();
        rst = 0;
        tick(); tick();
        all_zero("reset");
        rst = 1;
        tick();
        all_zero("post_reset");

        coin(2);
        chk("r27_c2", bus.credit, 2);
        coin(2);
        chk("r27_c4", bus.credit, 4);
        vend(0, 1, 1, 1, 0);

        for (int i = 0; i < 7; i++) coin(2);
        chk("r28_c14", bus.credit, 14);
        coin(2);
        coin(1);
        chk("r28_c15", bus.credit, 15);
        cancel_op();

        coin(2); coin(2);
        vend(3, 0, 0, 1, 0);
        chk("r29_credit", bus.credit, 4);
        cancel_op();

        coin(2); coin(2); coin(1);
        bus.vend_req = 1; bus.sel = 2;
        tick();
        clear_in();
        chk("r30_start", bus.disp_start, 1);
        bus.disp_ack = 1;
        tick();
        clear_in();
        k = 1;
        while (!bus.fault && k < TO + 5) begin
            tick();
            k++;
        end
        chk("r30_timeout_cycle", k, TO);
        chk("r30_credit", bus.credit, 5);
        chk("r30_fault_busy", bus.busy, 0);
        tick();
        chk("r30_change_busy", bus.busy, 1);
        m_credit = 5;
        change_out(5);
        chk("r30_sticky", {bus.fault, bus.busy}, 2'b10);

        coin(1); coin(2);
        bus.coin1 = 1; bus.vend_req = 1; bus.sel = 0; bus.cancel = 1;
        tick();
        clear_in();
        chk("r31_rej", bus.coin_rej, 1);
        chk("r31_no_start", bus.disp_start, 0);
        chk("r31_busy", bus.busy, 1);
        change_out(3);

        coin(2); coin(2); coin(2);
        bus.cancel = 1;
        tick();
        clear_in();
        tick(); tick(); tick();
        chk("r32_mid_credit", bus.credit, 4);
        rst = 0;
        tick();
        all_zero("r32_reset");
        rst = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.chg_pulse) cnt++;
        end
        chk("r32_no_pulse", cnt, 0);
        m_credit = 0;

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (op < 6) coin($urandom_range(1, 3));
            else if (op < 9) vend($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else cancel_op();
        end
        chk("rand_fault_clear", bus.fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
